// File: rtl/lsu.sv
// Load/store unit: one outstanding word-bus access per instruction,
// with sub-word store lane steering, load extension, misalign and timeout.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_wr_en,
  input  logic [2:0]  store_type,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LW  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    ltype_q, ltype_d;
  logic [1:0]    off_q, off_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic is_sb, is_sh, is_sw;
  logic store_v, load_v, pending, mis, go;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign is_sb   = store_type == 3'b001;
  assign is_sh   = store_type == 3'b010;
  assign is_sw   = store_type == 3'b100;
  assign store_v = d_wr_en & (is_sb | is_sh | is_sw);
  assign load_v  = ~store_v & (load_type != 3'b000);
  assign pending = store_v | load_v;

  // a store shadows any simultaneous load, including its alignment check
  always_comb begin
    mis = 1'b0;
    if (store_v)
      mis = (is_sh & addr[0]) | (is_sw & (addr[1:0] != 2'b00));
    else if (load_v)
      mis = (((load_type == LT_LH) | (load_type == LT_LHU)) & addr[0])
          | ((load_type == LT_LW) & (addr[1:0] != 2'b00));
  end

  assign go       = (state_q == S_IDLE) & pending & ~mis;
  assign misalign = (state_q == S_IDLE) & pending & mis;
  assign stall    = go | (state_q == S_REQ);
  assign bus_req  = state_q == S_REQ;
  assign bus_err  = (state_q == S_DONE) & err_q;

  always_comb begin
    st_be = 4'b1111;
    st_wd = wdata;
    unique case (1'b1)
      is_sb: begin
        st_be = 4'b0001 << addr[1:0];
        st_wd = {4{wdata[7:0]}};
      end
      is_sh: begin
        st_be = 4'b0011 << {addr[1], 1'b0};
        st_wd = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ltype_d = ltype_q;
    off_d   = off_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (go) begin
        state_d = S_REQ;
        addr_d  = {addr[31:2], 2'b00};
        we_d    = store_v;
        be_d    = store_v ? st_be : 4'b1111;
        wdata_d = store_v ? st_wd : 32'h0;
        ltype_d = store_v ? 3'b000 : load_type;
        off_d   = addr[1:0];
        wait_d  = '0;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      S_REQ: if (bus_ready) begin
        rdata_d = bus_rdata;
        state_d = S_DONE;
      end else begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      ltype_q <= 3'b000;
      off_q   <= 2'b00;
      wait_q  <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ltype_q <= ltype_d;
      off_q   <= off_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

  assign ld_b = rdata_q[{off_q, 3'b000} +: 8];
  assign ld_h = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    rdata_ext = 32'h0;
    if ((state_q == S_DONE) & ~we_q & ~err_q) begin
      case (ltype_q)
        LT_LB:   rdata_ext = {{24{ld_b[7]}}, ld_b};
        LT_LBU:  rdata_ext = {24'h0, ld_b};
        LT_LH:   rdata_ext = {{16{ld_h[15]}}, ld_h};
        LT_LHU:  rdata_ext = {16'h0, ld_h};
        default: rdata_ext = rdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized accesses
// checked against a transaction-level model of the unit.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_wr_en;
  logic [2:0]  store_type;
  logic [2:0]  load_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_ext;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .d_wr_en(d_wr_en), .store_type(store_type),
    .load_type(load_type), .addr(addr), .wdata(wdata),
    .rdata_ext(rdata_ext), .stall(stall),
    .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] obs_addr, obs_be, obs_wd, obs_rd, obs_err;
  logic [31:0] obs_mis, obs_req_seen;
  int stall_cnt, req_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    d_wr_en = 1'b0;
    store_type = 3'b000;
    load_type = 3'b000;
    addr = 32'h0;
    wdata = 32'h0;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
  endtask

  task automatic junk_in();
    d_wr_en = 1'($urandom);
    store_type = 3'($urandom);
    load_type = 3'($urandom);
    addr = $urandom;
    wdata = $urandom;
  endtask

  // one access from its IDLE cycle through DONE;
  // waits >= 4 means the bus never answers (TIMEOUT=4)
  task automatic do_access(input logic st,
                           input logic [2:0] stype,
                           input logic [2:0] ltype,
                           input logic [31:0] a,
                           input logic [31:0] wd,
                           input logic [31:0] rd,
                           input int waits);
    logic is_st, is_ld, mis, err;
    logic [31:0] sz, off, ebe, ewd, erd, b, h;
    int nreq;
    is_st = st && (stype == 3'd1 || stype == 3'd2 || stype == 3'd4);
    is_ld = !is_st && ltype != 3'd0;
    if (is_st) sz = (stype == 3'd1) ? 1 : (stype == 3'd2) ? 2 : 4;
    else if (ltype == 3'd1 || ltype == 3'd4) sz = 1;
    else if (ltype == 3'd2 || ltype == 3'd5) sz = 2;
    else sz = 4;
    off = a % 4;
    mis = (is_st || is_ld) && (a % sz != 0);
    d_wr_en = st; store_type = stype; load_type = ltype;
    addr = a; wdata = wd; bus_ready = 1'b0;
    stall_cnt = 0; req_cnt = 0;
    obs_mis = 0; obs_req_seen = 0;
    @(negedge clk);
    if (!is_st && !is_ld) begin
      chk("none_stall", 32'(stall), 0);
      chk("none_mis", 32'(misalign), 0);
      chk("none_req", 32'(bus_req), 0);
      @(posedge clk); #1;
      clr_in();
    end else if (mis) begin
      chk("mis_flag", 32'(misalign), 1);
      chk("mis_stall", 32'(stall), 0);
      chk("mis_req", 32'(bus_req), 0);
      obs_mis = 32'(misalign);
      stall_cnt += int'(stall);
      @(posedge clk); #1;
      clr_in();
      @(negedge clk);
      chk("mis_after_req", 32'(bus_req), 0);
      chk("mis_after_flag", 32'(misalign), 0);
      chk("mis_after_stall", 32'(stall), 0);
      obs_req_seen = 32'(bus_req);
      @(posedge clk); #1;
    end else begin
      chk("idle_stall", 32'(stall), 1);
      chk("idle_mis", 32'(misalign), 0);
      chk("idle_req", 32'(bus_req), 0);
      stall_cnt += int'(stall);
      ebe = 32'hF; ewd = wd; erd = 0;
      b = (rd >> (8 * off)) & 32'hFF;
      h = (rd >> (8 * (off & 2))) & 32'hFFFF;
      if (is_st) begin
        if (stype == 3'd1) begin
          ebe = 32'd1 << off;
          ewd = (wd & 32'hFF) * 32'h01010101;
        end else if (stype == 3'd2) begin
          ebe = 32'd3 << off;
          ewd = (wd & 32'hFFFF) * 32'h00010001;
        end
      end else begin
        case (ltype)
          3'd1: erd = (b >= 128) ? b + 32'hFFFFFF00 : b;
          3'd4: erd = b;
          3'd2: erd = (h >= 32768) ? h + 32'hFFFF0000 : h;
          3'd5: erd = h;
          default: erd = rd;
        endcase
      end
      err = waits >= 4;
      nreq = err ? 4 : waits + 1;
      if (err) erd = 0;
      for (int k = 0; k < nreq; k++) begin
        @(posedge clk); #1;
        junk_in();
        bus_ready = (k == waits);
        bus_rdata = (k == waits) ? rd : $urandom;
        @(negedge clk);
        chk("req_req", 32'(bus_req), 1);
        chk("req_stall", 32'(stall), 1);
        chk("req_addr", bus_addr, {a[31:2], 2'b00});
        chk("req_we", 32'(bus_we), 32'(is_st));
        chk("req_be", 32'(bus_be), ebe);
        if (is_st) chk("req_wdata", bus_wdata, ewd);
        chk("req_rdata", rdata_ext, 0);
        chk("req_err", 32'(bus_err), 0);
        if (k == 0) begin
          obs_addr = bus_addr;
          obs_be = 32'(bus_be);
          obs_wd = bus_wdata;
        end
        stall_cnt += int'(stall);
        req_cnt++;
      end
      @(posedge clk); #1;
      junk_in();
      bus_ready = 1'($urandom);
      bus_rdata = $urandom;
      @(negedge clk);
      chk("done_req", 32'(bus_req), 0);
      chk("done_stall", 32'(stall), 0);
      chk("done_mis", 32'(misalign), 0);
      chk("done_rdata", rdata_ext, erd);
      chk("done_err", 32'(bus_err), 32'(err));
      obs_rd = rdata_ext;
      obs_err = 32'(bus_err);
      stall_cnt += int'(stall);
      @(posedge clk); #1;
      clr_in();
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"}, 32'(bus_req), 0);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_we"}, 32'(bus_we), 0);
    chk({tag, "_be"}, 32'(bus_be), 0);
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_rdata"}, rdata_ext, 0);
    chk({tag, "_err"}, 32'(bus_err), 0);
    chk({tag, "_mis"}, 32'(misalign), 0);
  endtask

  initial begin
    logic st;
    logic [2:0] stype, ltype;
    logic [31:0] a;
    int kind, mode;
    reset = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_quiet("rst");
    @(posedge clk); #1;

    do_access(1'b1, 3'b001, 3'b000, 32'h1003, 32'hA5, 0, 0);
    chk("sb_addr", obs_addr, 32'h1000);
    chk("sb_be", obs_be, 32'h8);
    chk("sb_wdata", obs_wd, 32'hA5A5A5A5);
    chk("sb_stall_cycles", 32'(stall_cnt), 2);

    do_access(1'b0, 3'b000, 3'b001, 32'h2001, 0, 32'h00008000, 0);
    chk("lb_rdata", obs_rd, 32'hFFFFFF80);

    do_access(1'b0, 3'b000, 3'b101, 32'h2002, 0, 32'h9ABC1234, 0);
    chk("lhu_rdata", obs_rd, 32'h00009ABC);

    do_access(1'b0, 3'b000, 3'b011, 32'h0006, 0, 0, 0);
    chk("lw_mis_flag", obs_mis, 1);
    chk("lw_mis_noreq", obs_req_seen, 0);
    chk("lw_mis_stall", 32'(stall_cnt), 0);

    do_access(1'b0, 3'b000, 3'b011, 32'h0040, 0, 32'h12345678, 9);
    chk("to_req_cycles", 32'(req_cnt), 4);
    chk("to_err", obs_err, 1);
    chk("to_rdata", obs_rd, 0);

    // store held at the bus, reset lands in its second REQ cycle
    d_wr_en = 1'b1; store_type = 3'b100;
    addr = 32'h3000; wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rr_idle_stall", 32'(stall), 1);
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("rr_req1", 32'(bus_req), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rr_req2", 32'(bus_req), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    clr_in();
    @(negedge clk);
    chk_quiet("rr");
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      st = 1'b0; stype = 3'b000; ltype = 3'b000;
      if (kind <= 2) begin
        st = 1'b1;
        stype = 3'b001 << kind;
        if ($urandom_range(0, 3) == 0) ltype = 3'($urandom_range(1, 5));
      end else if (kind <= 7) begin
        ltype = 3'(kind - 2);
        if ($urandom_range(0, 3) == 0) st = 1'b1;
      end else begin
        st = 1'($urandom);
        stype = (kind == 8) ? 3'b011 : 3'b000;
      end
      a = $urandom;
      mode = $urandom_range(0, 2);
      if (mode == 1) a[0] = 1'b0;
      if (mode == 2) a[1:0] = 2'b00;
      do_access(st, stype, ltype, a, $urandom, $urandom,
                $urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
